// File: rtl/acum_dac_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acum_dac_tx_pkg
// Brief   : Shared sample format, saturation limits and FSM encoding for the
//           accumulator-to-DAC transmit path.
// Rev     : 1.0  initial release
// ============================================================================
package acum_dac_tx_pkg;

  // Must match the accumulator that feeds this block.
  localparam int N_DEF = 25;
  localparam int F_DEF = 16;

  localparam logic [N_DEF-1:0] MAX_S = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] MIN_S = {1'b1, {(N_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/acum_dac_tx_sat_round.sv
`default_nettype none
// ============================================================================
// Module  : acum_dac_tx_sat_round
// Brief   : Combinational 2N->N conversion (2F -> F fractional bits) with
//           saturation. ACUM_DAC_TX_ROUND_EN selects round-half-up, else floor.
// Rev     : 1.0  initial release
// ============================================================================
module acum_dac_tx_sat_round
  import acum_dac_tx_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic [2*N-1:0] acc_i,
  output logic [N-1:0]   smp_o
);

  logic [2*N:0]   w_t;
  logic [N-F+1:0] w_hi;
  logic           w_ovf;
  logic [N-1:0]   w_max;
  logic [N-1:0]   w_min;
  logic           w_unused_frac;

`ifdef ACUM_DAC_TX_ROUND_EN
  localparam logic [2*N:0] C_HALF = {{(2*N){1'b0}}, 1'b1} << (F-1);
  assign w_t = {acc_i[2*N-1], acc_i} + C_HALF;
`else
  assign w_t = {acc_i[2*N-1], acc_i};
`endif

  // One extra sign bit keeps a rounding carry out of the top from flipping the sign.
  assign w_hi          = w_t[2*N:N+F-1];
  assign w_ovf         = !((&w_hi) || !(|w_hi));
  assign w_unused_frac = ^w_t[F-1:0];

  generate
    if (N == N_DEF) begin : g_pkg_lim
      assign w_max = MAX_S;
      assign w_min = MIN_S;
    end else begin : g_gen_lim
      assign w_max = {1'b0, {(N-1){1'b1}}};
      assign w_min = {1'b1, {(N-1){1'b0}}};
    end
  endgenerate

  assign smp_o = w_ovf ? (w_t[2*N] ? w_min : w_max) : w_t[N+F-1:F];

endmodule
`default_nettype wire

// File: rtl/acum_dac_tx.sv
`default_nettype none
// ============================================================================
// Module  : acum_dac_tx
// Brief   : Converts the accumulated filter result to an N-bit sample, reduces
//           it to an offset-binary DAC code and shifts it out on sclk/sync_n/
//           sdata. Build option ACUM_DAC_TX_ROUND_EN enables rounding.
// Rev     : 1.0  initial release
// ============================================================================
module acum_dac_tx
  import acum_dac_tx_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int F   = F_DEF,
  parameter int D   = 12,
  parameter int DIV = 4,
  parameter int PAD = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2*N-1:0] In,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   muestra,
  output logic [D-1:0]   dac_code,
  output logic           sclk,
  output logic           sync_n,
  output logic           sdata,
  output logic           busy
);

  localparam int FRAME_W = PAD + D;
  localparam int CNT_W   = $clog2(2*DIV + 1);
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam logic [D-1:0] C_CODE_MSB = '1 ^ ('1 >> 1);

  state_e               state_q, state_d;
  logic [2*N-1:0]       in_q, in_d;
  logic [N-1:0]         muestra_q, muestra_d;
  logic [D-1:0]         code_q, code_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     fall_q, fall_d;
  logic                 sclk_q, sclk_d;
  logic                 sync_n_q, sync_n_d;
  logic                 sdata_q, sdata_d;

  logic [N-1:0]         w_sample;
  logic [D-1:0]         w_code;
  logic [FRAME_W-1:0]   w_frame;

  acum_dac_tx_sat_round #(
    .N (N),
    .F (F)
  ) u_sat_round (
    .acc_i (in_q),
    .smp_o (w_sample)
  );

  // Offset binary: invert the sign bit of the top D bits.
  assign w_code  = w_sample[N-1 -: D] ^ C_CODE_MSB;
  assign w_frame = FRAME_W'(w_code);

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    muestra_d = muestra_q;
    code_d    = code_q;
    sr_d      = sr_q;
    div_d     = div_q;
    fall_d    = fall_q;
    sclk_d    = sclk_q;
    sync_n_d  = sync_n_q;
    sdata_d   = sdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_d    = In;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        muestra_d = w_sample;
        code_d    = w_code;
        sr_d      = w_frame;
        sdata_d   = w_frame[FRAME_W-1];
        sync_n_d  = 1'b0;
        sclk_d    = 1'b0;
        div_d     = '0;
        fall_d    = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == CNT_W'(DIV-1)) begin
          div_d = '0;
          if (!sclk_q) begin
            // The shifter advances on falling edges; sdata only picks it up on the next rise.
            sclk_d  = 1'b1;
            sdata_d = sr_q[FRAME_W-1];
          end else begin
            sclk_d = 1'b0;
            sr_d   = sr_q << 1;
            fall_d = fall_q + BIT_W'(1);
            if (fall_q == BIT_W'(FRAME_W-1)) begin
              sync_n_d = 1'b1;
              state_d  = S_GAP;
            end
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (div_q == CNT_W'(2*DIV-1)) begin
          div_d   = '0;
          sdata_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      in_q      <= '0;
      muestra_q <= '0;
      code_q    <= '0;
      sr_q      <= '0;
      div_q     <= '0;
      fall_q    <= '0;
      sclk_q    <= 1'b0;
      sync_n_q  <= 1'b1;
      sdata_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      muestra_q <= muestra_d;
      code_q    <= code_d;
      sr_q      <= sr_d;
      div_q     <= div_d;
      fall_q    <= fall_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      sdata_q   <= sdata_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign muestra  = muestra_q;
  assign dac_code = code_q;
  assign sclk     = sclk_q;
  assign sync_n   = sync_n_q;
  assign sdata    = sdata_q;

endmodule
`default_nettype wire

// File: tb/tb_acum_dac_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_acum_dac_tx
// Brief   : Scoreboard bench for acum_dac_tx: random and directed accumulator
//           values against an arithmetic reference of the conversion and link.
// Rev     : 1.0  initial release
// ============================================================================
module tb_acum_dac_tx;

  localparam int N         = 25;
  localparam int F         = 16;
  localparam int D         = 12;
  localparam int DIV       = 4;
  localparam int PAD       = 4;
  localparam int FRAME_W   = PAD + D;
  localparam int FRAME_CYC = 2*DIV*FRAME_W;
  localparam int READY_CYC = 2*DIV*(FRAME_W+1) + 2;

  logic           clk      = 1'b0;
  logic           reset_n  = 1'b1;
  logic           in_valid = 1'b0;
  logic [2*N-1:0] In       = '0;
  logic           in_ready;
  logic [N-1:0]   muestra;
  logic [D-1:0]   dac_code;
  logic           sclk;
  logic           sync_n;
  logic           sdata;
  logic           busy;

  acum_dac_tx #(.N(N), .F(F), .D(D), .DIV(DIV), .PAD(PAD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .In       (In),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .muestra  (muestra),
    .dac_code (dac_code),
    .sclk     (sclk),
    .sync_n   (sync_n),
    .sdata    (sdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] m;
    logic [D-1:0] c;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: signed arithmetic on the real value, then clamp and offset.
  function automatic exp_t model(input logic [2*N-1:0] x, input int at);
    exp_t   e;
    longint v, q, lim;
    lim = longint'(1) <<< (N-1);
    v   = longint'($signed(x));
`ifdef ACUM_DAC_TX_ROUND_EN
    v = v + (longint'(1) <<< (F-1));
`endif
    q = v >>> F;
    if (q > lim - 1) q = lim - 1;
    if (q < -lim)    q = -lim;
    e.m   = N'(q);
    e.c   = D'((q + lim) >>> (N-D));
    e.acc = at;
    return e;
  endfunction

  // Monitor / scoreboard
  logic               p_sync  = 1'b1;
  logic               p_sclk  = 1'b0;
  logic               p_sdata = 1'b0;
  logic               p_rdy   = 1'b1;
  bit                 in_frame = 1'b0;
  bit                 rdy_bad  = 1'b0;
  int                 falls    = 0;
  int                 start_cyc = 0;
  int                 last_acc  = 0;
  logic [FRAME_W-1:0] bits     = '0;
  logic [FRAME_W-1:0] exp_bits = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      p_sync   = 1'b1;
      p_sclk   = 1'b0;
      p_sdata  = 1'b0;
      p_rdy    = 1'b1;
    end else begin
      if (!p_rdy && in_ready)
        chk("ready_return", 64'(cyc - last_acc), 64'(READY_CYC));
      if (in_valid && in_ready) begin
        sb.push_back(model(In, cyc));
        acc_log.push_back(cyc);
        last_acc = cyc;
      end
      if (in_frame && p_sclk && !sclk) begin
        chk("sdata_stable", 64'(sdata), 64'(p_sdata));
        bits  = {bits[FRAME_W-2:0], sdata};
        falls = falls + 1;
      end
      if (in_frame && in_ready) rdy_bad = 1'b1;
      if (in_frame && !p_sync && sync_n) begin
        chk("fall_count", 64'(falls), 64'(FRAME_W));
        chk("frame_bits", 64'(bits), 64'(exp_bits));
        chk("frame_len", 64'(cyc - start_cyc), 64'(FRAME_CYC));
        chk("sclk_low_at_end", 64'(sclk), 64'd0);
        chk("ready_low_in_frame", 64'(rdy_bad), 64'd0);
        in_frame = 1'b0;
      end
      if (p_sync && !sync_n) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("muestra", 64'(muestra), 64'(e.m));
          chk("dac_code", 64'(dac_code), 64'(e.c));
          chk("start_latency", 64'(cyc - e.acc), 64'd2);
          chk("busy_at_start", 64'(busy), 64'd1);
          exp_bits = FRAME_W'(e.c);
        end
        in_frame  = 1'b1;
        rdy_bad   = 1'b0;
        falls     = 0;
        bits      = '0;
        start_cyc = cyc;
      end
      p_sync  = sync_n;
      p_sclk  = sclk;
      p_sdata = sdata;
      p_rdy   = in_ready;
    end
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: in_ready actual 0 required 1 after %0d cycles", nm, n);
    end
  endtask

  task automatic send_one(input logic [2*N-1:0] v);
    wait_ready("wait_idle");
    In       = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ready("frame_done");
  endtask

  function automatic logic [2*N-1:0] rnd_acc();
    logic [63:0]          r;
    logic signed [2*N-1:0] s;
    r = {$urandom, $urandom};
    s = r[2*N-1:0];
    s = s >>> $urandom_range(0, 2*N-1);
    return s;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_sync_n", 64'(sync_n), 64'd1);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_muestra", 64'(muestra), 64'd0);
    chk("rst_dac_code", 64'(dac_code), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed: 1.0, both saturation rails, half LSB, zero twice
    send_one(50'd1 << 32);
    send_one(50'd1 << 48);
    send_one(-(50'd1 << 48));
    send_one(50'h8000);
    send_one('0);
    send_one('0);
    send_one({1'b0, {(2*N-1){1'b1}}});
    send_one({1'b1, {(2*N-1){1'b0}}});

    for (int i = 0; i < 15; i++) send_one(rnd_acc());

    // Back-to-back: in_valid held high, new random value every cycle
    acc_log.delete();
    in_valid = 1'b1;
    repeat (3*READY_CYC + 5) begin
      In = rnd_acc();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_ready("stream_done");
    chk("stream_accepts", 64'(acc_log.size()), 64'd4);
    for (int i = 1; i < acc_log.size(); i++)
      chk("stream_gap", 64'(acc_log[i] - acc_log[i-1]), 64'(READY_CYC));

    // Reset in the middle of a frame
    In       = rnd_acc();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(in_frame && falls >= 7) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_bit7", 64'(in_frame && falls >= 7), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_sclk", 64'(sclk), 64'd1);
    chk("pre_rst_sync_n", 64'(sync_n), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_sync_n", 64'(sync_n), 64'd1);
    chk("abort_sclk", 64'(sclk), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_muestra", 64'(muestra), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send_one(50'd3 << 40);
    send_one(rnd_acc());

    repeat (5) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
